pulse_width_meter: RTL and testbench
====================================

# pulse_width_meter

Multi-channel synthesizable pulse-width measurement block: counts the clock edges during which each input is high and reports the width when the pulse ends. Completed measurements are queued per channel and drained through one valid/ready result port with round-robin arbitration. Sits between asynchronous-origin (pre-synchronised) control strobes and a monitor/logging agent.

## Interface
- NCH, 4: number of input channels (1..32).
- CW, 8: width counter bits; max reportable width 2^CW-1.
- CHW, $clog2(NCH) (min 1): channel index width (derived, not overridable).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  NCH  pulse inputs, already synchronous to clk.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result when high with res_valid.
- res_ch  out  CHW  channel of current result.
- res_width  out  CW  measured width in clk edges.
- res_sat  out  1  width saturated at 2^CW-1.
- ovr  out  NCH  sticky per-channel overrun flags.
- ovr_clr  in  NCH  per-channel synchronous clear of ovr.

## Operation
- Per channel: prev[i] (last sample), cnt[i], sat[i], pend[i], pend_w[i], pend_s[i].
- Sampling at each posedge; "high sample" = sig_in[i]==1 at that edge.
- Rise (sig & !prev): cnt=1, sat=0.
- High and prev high: cnt+1; at 2^CW-1 cnt holds, sat=1.
- Fall (!sig & prev): pend_w=cnt, pend_s=sat, pend=1; counter idle.
- Width = number of consecutive high samples (1-cycle pulse reports 1).
- Overrun: fall while pend[i]=1 and channel i not granted this edge -> pend_w/pend_s overwritten with newest, ovr[i]=1. If granted the same edge, new capture loads pend, no overrun.
- ovr_clr[i] clears ovr[i]; simultaneous set wins over clear.
- Output register loads when (!res_valid || res_ready) and any pend=1: grant first pending channel strictly after last-granted index, wrapping; clears that pend; updates last-granted.
- If no pend and res_ready, res_valid drops.
- Outputs hold stable while res_valid && !res_ready.

## Timing
- Reset values: res_valid=0, res_ch=0, res_width=0, res_sat=0, ovr=0; prev=0, pend=0, last-granted=NCH-1 (channel 0 wins first).
- prev=0 after reset: an input already high at first edge counts as a rise.
- Latency: fall sampled at edge N -> pend at N; res_valid at N+1 if output register free or consumed at N+1.
- Sustained throughput: one result per cycle with res_ready=1.
- Minimum per-channel capture spacing is 2 cycles; no same-edge capture collision with its own grant other than rule above.
- Reset asserted mid-pulse: count discarded, no result emitted; pulse still high after release is measured from release as a new rise.

## Configuration
- PULSE_WIDTH_METER_SVA_EN: when defined, compiles in concurrent assertions (clocked at posedge clk, disabled iff !rst_n): per channel, a local-variable property counting high samples from rise and checking pend_w equals that count (or 2^CW-1 with pend_s) on fall; res_valid && !res_ready |=> stable outputs; res_ch < NCH; no pend cleared without grant. Failures report via $error with channel and expected count. Undefined: no assertion code; RTL behaviour identical.

## Test plan
- NCH=4, CW=8: ch0 high 12 edges, rest low, res_ready=1 -> one result ch=0 width=12 sat=0, res_valid one cycle after fall.
- ch1 1-cycle pulse -> width=1; CW=4, ch2 high 20 edges -> width=15, sat=1.
- Falls on ch0..ch3 same edge, res_ready=1 -> results ch0,1,2,3 on consecutive cycles; repeat -> order continues from ch0 after ch3 wraps.
- res_ready=0 while ch3 produces widths 5 then 7 -> ovr[3]=1, later single result width=7; ovr_clr[3] pulse -> ovr[3]=0.
- rst_n low for 2 cycles mid ch0 pulse of 10 -> no result; outputs at reset values; remaining 4 high edges after release -> width=4.
- res_ready toggling 0/1 with all channels pulsing width 3 every 4 cycles -> outputs stable under backpressure, no lost results except flagged ovr.

Source files
------------

// File: rtl/pulse_width_meter.sv
// Multi-channel pulse-width meter: counts high samples per channel, parks each finished width
// in a one-deep per-channel slot and drains the slots round-robin through a valid/ready port.
// Optional: define PULSE_WIDTH_METER_SVA_EN to compile in concurrent assertions.
module pulse_width_meter #(
  parameter  int NCH = 4,
  parameter  int CW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] sig_in,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [CHW-1:0] res_ch,
  output logic [CW-1:0]  res_width,
  output logic           res_sat,
  output logic [NCH-1:0] ovr,
  input  logic [NCH-1:0] ovr_clr
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NCH-1:0] prev, sat, pend, pend_s;
  logic [CW-1:0]  cnt    [NCH];
  logic [CW-1:0]  pend_w [NCH];
  logic [CHW-1:0] last_grant, grant_idx;
  logic           grant_load;
  logic [NCH-1:0] grant_oh;

  // Round-robin search starting just after the last granted channel; the nearest
  // pending channel is assigned last, so it wins.
  always_comb begin : arbiter
    int idx;
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    idx       = 0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NCH) idx -= NCH;
      if (pend[CHW'(idx)]) grant_idx = CHW'(idx);
    end
    grant_load = (|pend) && (!res_valid || res_ready);
    if (grant_load) grant_oh[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel arrays are small flop banks rather than RAM, so they are reset too.
      prev       <= '0;
      sat        <= '0;
      pend       <= '0;
      pend_s     <= '0;
      ovr        <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        pend_w[i] <= '0;
      end
      last_grant <= CHW'(NCH - 1);
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_width  <= '0;
      res_sat    <= '0;
    end else begin
      // NOTE: non-blocking updates mean every read below sees the pre-edge state.
      for (int i = 0; i < NCH; i++) begin
        prev[i] <= sig_in[i];
        if (sig_in[i] && !prev[i]) begin
          cnt[i] <= CW'(1);
          sat[i] <= 1'b0;
        end else if (sig_in[i]) begin
          if (cnt[i] == CNT_MAX) sat[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
        end

        // A fresh capture always lands in the slot; a same-edge grant took the old contents.
        if (!sig_in[i] && prev[i]) begin
          pend_w[i] <= cnt[i];
          pend_s[i] <= sat[i];
          pend[i]   <= 1'b1;
        end else if (grant_oh[i]) begin
          pend[i]   <= 1'b0;
        end

        if (!sig_in[i] && prev[i] && pend[i] && !grant_oh[i]) ovr[i] <= 1'b1;
        else if (ovr_clr[i])                                  ovr[i] <= 1'b0;
      end

      if (grant_load) begin
        res_valid  <= 1'b1;
        res_ch     <= grant_idx;
        res_width  <= pend_w[grant_idx];
        res_sat    <= pend_s[grant_idx];
        last_grant <= grant_idx;
      end else if (res_ready) begin
        res_valid  <= 1'b0;
      end
    end
  end

`ifdef PULSE_WIDTH_METER_SVA_EN
  // Exact (unsaturated) run length, kept only to make failure messages informative.
  int unsigned sva_run [NCH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) sva_run[i] <= 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (sig_in[i]) sva_run[i] <= prev[i] ? sva_run[i] + 1 : 1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_sva
    property p_width;
      int unsigned n;
      @(posedge clk) disable iff (!rst_n)
        (sig_in[g] && !prev[g], n = 1) ##1 (sig_in[g], n = n + 1)[*0:$] ##1 !sig_in[g]
        |=> ((n > int'(CNT_MAX)) ? (pend_w[g] == CNT_MAX && pend_s[g])
                                 : (pend_w[g] == CW'(n) && !pend_s[g]));
    endproperty
    a_width: assert property (p_width)
      else $error("channel %0d: pend_w=%0d sat=%0b, expected count %0d",
                  g, pend_w[g], pend_s[g], sva_run[g]);

    a_pend_grant: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(pend[g]) |-> $past(grant_oh[g]))
      else $error("channel %0d: pend cleared without grant", g);
  end

  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      res_valid && !res_ready |=> $stable({res_valid, res_ch, res_width, res_sat}))
    else $error("result changed under backpressure");

  a_ch_range: assert property (@(posedge clk) disable iff (!rst_n)
      int'(res_ch) < NCH)
    else $error("res_ch %0d out of range", res_ch);
`else
  // Assertions compiled out; datapath behaviour is identical.
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter (NCH=4, CW=8): directed scenarios plus random pulses,
// every cycle compared against an integer run-length / mailbox reference model.
module tb_pulse_width_meter;

  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int MAXW = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] sig_in;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_ch;
  logic [CW-1:0]  res_width;
  logic           res_sat;
  logic [NCH-1:0] ovr;
  logic [NCH-1:0] ovr_clr;

  int vectors     = 0;
  int miscompares = 0;

  pulse_width_meter #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_width (res_width),
    .res_sat   (res_sat),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  // Reference model: exact run lengths, one mailbox per channel, one output slot.
  int       m_run  [NCH];
  bit       m_hp   [NCH];
  bit       m_full [NCH];
  int       m_pw   [NCH];
  bit       m_ps   [NCH];
  int       m_last;
  bit       m_valid;
  int       m_ch, m_w;
  bit       m_s;
  bit [NCH-1:0] m_ovr;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_hp[c] = 0; m_full[c] = 0; m_pw[c] = 0; m_ps[c] = 0;
    end
    m_last = NCH - 1; m_valid = 0; m_ch = 0; m_w = 0; m_s = 0; m_ovr = '0;
  endtask

  task automatic model_edge();
    int g;
    bit load;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = -1;
    for (int k = 1; k <= NCH; k++)
      if (g < 0 && m_full[(m_last + k) % NCH]) g = (m_last + k) % NCH;
    load = (g >= 0) && (!m_valid || res_ready);
    if (load) begin
      m_valid = 1; m_ch = g; m_w = m_pw[g]; m_s = m_ps[g]; m_last = g;
    end else if (res_ready) begin
      m_valid = 0;
    end
    for (int c = 0; c < NCH; c++) begin
      if (ovr_clr[c]) m_ovr[c] = 0;
      if (!sig_in[c] && m_hp[c]) begin
        if (m_full[c] && !(load && g == c)) m_ovr[c] = 1;
        m_full[c] = 1;
        m_pw[c]   = (m_run[c] > MAXW) ? MAXW : m_run[c];
        m_ps[c]   = (m_run[c] > MAXW);
      end else if (load && g == c) begin
        m_full[c] = 0;
      end
      m_run[c] = sig_in[c] ? (m_hp[c] ? m_run[c] + 1 : 1) : 0;
      m_hp[c]  = sig_in[c];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic compare_model();
    check("res_valid", res_valid, m_valid);
    if (m_valid) begin
      check("res_ch", res_ch, m_ch);
      check("res_width", res_width, m_w);
      check("res_sat", res_sat, m_s);
    end
    check("ovr", ovr, m_ovr);
  endtask

  // One clock: model advances on the same edge as the DUT, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sig_in = '0; res_ready = 1'b1; ovr_clr = '0;
    model_reset();

    // Reset state.
    run(2);
    check("rst_valid", res_valid, 0);
    check("rst_ch", res_ch, 0);
    check("rst_width", res_width, 0);
    check("rst_sat", res_sat, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1'b1;

    // ch0 high 12 edges: result one cycle after the fall.
    sig_in = 4'b0001; run(12);
    sig_in = 4'b0000; step();
    check("w12_latency", res_valid, 0);
    step();
    check("w12_valid", res_valid, 1);
    check("w12_ch", res_ch, 0);
    check("w12_width", res_width, 12);
    check("w12_sat", res_sat, 0);
    step();
    check("w12_drop", res_valid, 0);

    // ch1 single-cycle pulse.
    sig_in = 4'b0010; step();
    sig_in = 4'b0000; run(2);
    check("w1_ch", res_ch, 1);
    check("w1_width", res_width, 1);

    // Saturation boundary on ch2: 300 edges saturates, exactly 255 does not.
    sig_in = 4'b0100; run(300);
    sig_in = 4'b0000; run(2);
    check("sat_width", res_width, MAXW);
    check("sat_flag", res_sat, 1);
    sig_in = 4'b0100; run(MAXW);
    sig_in = 4'b0000; run(2);
    check("max_width", res_width, MAXW);
    check("max_flag", res_sat, 0);

    // Simultaneous falls: round-robin from ch0, and again after wrapping past ch3.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      sig_in = 4'b1111; run(3);
      sig_in = 4'b0000; step();
      for (int c = 0; c < NCH; c++) begin
        step();
        check("rr_ch", res_ch, c);
        check("rr_width", res_width, 3);
      end
    end
    step();

    // Overrun on ch3 while the output register is stalled.
    res_ready = 1'b0;
    sig_in = 4'b0001; run(2);
    sig_in = 4'b0000; run(2);
    sig_in = 4'b1000; run(5);
    sig_in = 4'b0000; run(2);
    check("ovr_before", ovr[3], 0);
    sig_in = 4'b1000; run(7);
    sig_in = 4'b0000; run(2);
    check("ovr_set", ovr[3], 1);
    check("stall_ch", res_ch, 0);
    res_ready = 1'b1; step();
    check("ovr_res_ch", res_ch, 3);
    check("ovr_res_width", res_width, 7);
    step();
    check("ovr_single", res_valid, 0);
    ovr_clr = 4'b1000; step();
    ovr_clr = 4'b0000;
    check("ovr_clr", ovr[3], 0);

    // Reset in the middle of a ch0 pulse of 10.
    sig_in = 4'b0001; run(4);
    rst_n = 1'b0; run(2);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_width", res_width, 0);
    rst_n = 1'b1; run(4);
    sig_in = 4'b0000; step();
    check("mid_rst_none", res_valid, 0);
    step();
    check("mid_rst_ch", res_ch, 0);
    check("mid_rst_width4", res_width, 4);
    step();

    // All channels width 3 every 4 cycles under toggling backpressure.
    for (int cyc = 0; cyc < 48; cyc++) begin
      sig_in    = (cyc % 4 != 3) ? 4'b1111 : 4'b0000;
      res_ready = cyc[0];
      step();
    end

    // Random pulses, backpressure and overrun clears.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) sig_in[c] = ~sig_in[c];
      res_ready = ($urandom_range(0, 2) != 0);
      ovr_clr   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      step();
    end

    sig_in = '0; res_ready = 1'b1; ovr_clr = '0;
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
